// File: rtl/motor_drive.sv
// Motor drive stage: debounces the tracker steering state, ramps per-wheel duty
// toward a per-state target and drives registered PWM plus H-bridge direction.
module motor_drive #(
   parameter int PWM_PERIOD  = 100,
   parameter int FWD_DUTY    = 80,
   parameter int TURN_FAST   = 70,
   parameter int TURN_SLOW   = 20,
   parameter int RAMP_STEP   = 10,
   parameter int RAMP_DIV    = 50,
   parameter int HOLD_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] mode,
   output logic       left_pwm,
   output logic       right_pwm,
   output logic [1:0] left_dir,
   output logic [1:0] right_dir,
   output logic [1:0] motion
);

   localparam int W  = $clog2(PWM_PERIOD + 1);
   localparam int PW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
   localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int HW = $clog2(HOLD_CYCLES + 1);

   typedef enum logic [1:0] {
      STOP  = 2'b00,
      LEFT  = 2'b01,
      RIGHT = 2'b10,
      FWD   = 2'b11
   } state_t;

   state_t         state_q, state_d;
   logic [1:0]     cand_q, cand_d;
   logic [HW-1:0]  stable_q, stable_d;
   logic [RW-1:0]  rampCnt_q, rampCnt_d;
   logic [PW-1:0]  pwmCnt_q, pwmCnt_d;
   logic [W-1:0]   curLeft_q, curLeft_d, curRight_q, curRight_d;
   logic [W-1:0]   actLeft_q, actLeft_d, actRight_q, actRight_d;
   logic           pwmLeft_q, pwmLeft_d, pwmRight_q, pwmRight_d;
   logic [W-1:0]   tgtLeft, tgtRight;
   logic           rampTick, pwmWrap, enterStop;

   // Saturating move of one wheel's duty toward its target by one ramp step.
   function automatic logic [W-1:0] stepToward(input logic [W-1:0] cur,
                                               input logic [W-1:0] tgt);
      int c;
      int t;
      c = int'(cur);
      t = int'(tgt);
      if (c < t)
         c = (c + RAMP_STEP > t) ? t : c + RAMP_STEP;
      else if (c > t)
         c = (c - RAMP_STEP < t) ? t : c - RAMP_STEP;
      return W'(c);
   endfunction

   always_comb begin
      cand_d   = mode;
      stable_d = stable_q;
      state_d  = state_q;
      if (mode != cand_q)
         stable_d = HW'(1);
      else if (stable_q < HW'(HOLD_CYCLES))
         stable_d = stable_q + HW'(1);
      if (stable_d == HW'(HOLD_CYCLES) && cand_d != state_q)
         state_d = state_t'(cand_d);
   end

   // Targets follow the currently adopted state, so a tick coinciding with
   // adoption still steps toward the old target.
   always_comb begin
      tgtLeft  = '0;
      tgtRight = '0;
      unique case (state_q)
         STOP:  begin tgtLeft = '0;               tgtRight = '0;               end
         LEFT:  begin tgtLeft = W'(TURN_SLOW);    tgtRight = W'(TURN_FAST);    end
         RIGHT: begin tgtLeft = W'(TURN_FAST);    tgtRight = W'(TURN_SLOW);    end
         FWD:   begin tgtLeft = W'(FWD_DUTY);     tgtRight = W'(FWD_DUTY);     end
      endcase
   end

   always_comb begin
      rampTick   = (rampCnt_q == RW'(RAMP_DIV - 1));
      pwmWrap    = (pwmCnt_q == PW'(PWM_PERIOD - 1));
      enterStop  = (state_d == STOP) && (state_q != STOP);
      rampCnt_d  = rampTick ? '0 : rampCnt_q + RW'(1);
      pwmCnt_d   = pwmWrap ? '0 : pwmCnt_q + PW'(1);
      curLeft_d  = curLeft_q;
      curRight_d = curRight_q;
      actLeft_d  = actLeft_q;
      actRight_d = actRight_q;
      if (enterStop) begin
         curLeft_d  = '0;
         curRight_d = '0;
      end else if (rampTick) begin
         curLeft_d  = stepToward(curLeft_q, tgtLeft);
         curRight_d = stepToward(curRight_q, tgtRight);
      end
      if (enterStop) begin
         actLeft_d  = '0;
         actRight_d = '0;
      end else if (pwmWrap) begin
         actLeft_d  = curLeft_q;
         actRight_d = curRight_q;
      end
      pwmLeft_d  = !enterStop && (int'(pwmCnt_q) < int'(actLeft_q));
      pwmRight_d = !enterStop && (int'(pwmCnt_q) < int'(actRight_q));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= STOP;
         cand_q     <= 2'b00;
         stable_q   <= '0;
         rampCnt_q  <= '0;
         pwmCnt_q   <= '0;
         curLeft_q  <= '0;
         curRight_q <= '0;
         actLeft_q  <= '0;
         actRight_q <= '0;
         pwmLeft_q  <= 1'b0;
         pwmRight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cand_q     <= cand_d;
         stable_q   <= stable_d;
         rampCnt_q  <= rampCnt_d;
         pwmCnt_q   <= pwmCnt_d;
         curLeft_q  <= curLeft_d;
         curRight_q <= curRight_d;
         actLeft_q  <= actLeft_d;
         actRight_q <= actRight_d;
         pwmLeft_q  <= pwmLeft_d;
         pwmRight_q <= pwmRight_d;
      end
   end

   assign motion    = state_q;
   assign left_dir  = (state_q == STOP) ? 2'b00 : 2'b10;
   assign right_dir = (state_q == STOP) ? 2'b00 : 2'b10;
   assign left_pwm  = pwmLeft_q;
   assign right_pwm = pwmRight_q;

endmodule

// File: tb/tb_motor_drive.sv
// Directed bench for motor_drive: debounce, ramping, STOP override, reset abort
// and a full-duty / zero-duty parameter variant.
module tb_motor_drive;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] mode = 2'b00;
   logic       left_pwm, right_pwm;
   logic [1:0] left_dir, right_dir, motion;

   logic       reset2 = 1'b1;
   logic [1:0] mode2 = 2'b00;
   logic       left_pwm2, right_pwm2;
   logic [1:0] left_dir2, right_dir2, motion2;

   int total = 0;
   int bad = 0;
   int sinceReset = 0;
   bit track = 1'b0;
   int phaseErr = 0;
   logic       prevL = 1'b0, prevR = 1'b0;
   logic [6:0] prevActL = '0, prevActR = '0;

   motor_drive dut (
      .clk(clk), .reset(reset), .mode(mode),
      .left_pwm(left_pwm), .right_pwm(right_pwm),
      .left_dir(left_dir), .right_dir(right_dir), .motion(motion)
   );

   motor_drive #(.FWD_DUTY(100), .TURN_SLOW(0)) dut2 (
      .clk(clk), .reset(reset2), .mode(mode2),
      .left_pwm(left_pwm2), .right_pwm(right_pwm2),
      .left_dir(left_dir2), .right_dir(right_dir2), .motion(motion2)
   );

   always #5 clk = ~clk;

   // Edges since reset release; the PWM counter after edge n is n mod 100.
   always @(posedge clk) begin
      if (reset) sinceReset <= 0;
      else sinceReset <= sinceReset + 1;
   end

   task automatic stepCycle();
      @(negedge clk);
      if (track) begin
         if (left_pwm && !prevL && (sinceReset % 100) != 1) phaseErr++;
         if (right_pwm && !prevR && (sinceReset % 100) != 1) phaseErr++;
         if (dut.actLeft_q !== prevActL && (sinceReset % 100) != 0) phaseErr++;
         if (dut.actRight_q !== prevActR && (sinceReset % 100) != 0) phaseErr++;
      end
      prevL    = left_pwm;
      prevR    = right_pwm;
      prevActL = dut.actLeft_q;
      prevActR = dut.actRight_q;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      mode  = 2'b00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (motion !== 2'b00) begin
         bad++; $display("[TB] FAIL reset_motion: got %b want 00", motion);
      end
      total++;
      if ({left_dir, right_dir} !== 4'b0000) begin
         bad++; $display("[TB] FAIL reset_dir: got %b want 0000", {left_dir, right_dir});
      end
      total++;
      if ({left_pwm, right_pwm} !== 2'b00) begin
         bad++; $display("[TB] FAIL reset_pwm: got %b want 00", {left_pwm, right_pwm});
      end
      reset = 1'b0;
   endtask

   task automatic test_fwd_ramp();
      logic [6:0] prev;
      bit got;
      int hl, hr;
      mode = 2'b11;
      repeat (3) stepCycle();
      total++;
      if (motion !== 2'b00) begin
         bad++; $display("[TB] FAIL fwd_early: got %b want 00", motion);
      end
      stepCycle();
      total++;
      if (motion !== 2'b11) begin
         bad++; $display("[TB] FAIL fwd_adopt: got %b want 11", motion);
      end
      total++;
      if ({left_dir, right_dir} !== 4'b1010) begin
         bad++; $display("[TB] FAIL fwd_dir: got %b want 1010", {left_dir, right_dir});
      end
      for (int k = 1; k <= 8; k++) begin
         prev = dut.curLeft_q;
         got = 1'b0;
         for (int i = 0; i < 60 && !got; i++) begin
            stepCycle();
            if (dut.curLeft_q !== prev) got = 1'b1;
         end
         total++;
         if (!got || dut.curLeft_q !== 7'(10 * k)) begin
            bad++; $display("[TB] FAIL fwd_ramp_left%0d: got %0d want %0d", k, dut.curLeft_q, 10 * k);
         end
         total++;
         if (dut.curRight_q !== 7'(10 * k)) begin
            bad++; $display("[TB] FAIL fwd_ramp_right%0d: got %0d want %0d", k, dut.curRight_q, 10 * k);
         end
      end
      repeat (150) stepCycle();
      hl = 0; hr = 0;
      for (int i = 0; i < 100; i++) begin
         stepCycle();
         hl += int'(left_pwm);
         hr += int'(right_pwm);
      end
      total++;
      if (hl != 80 || hr != 80) begin
         bad++; $display("[TB] FAIL fwd_steady_highs: got %0d/%0d want 80/80", hl, hr);
      end
   endtask

   task automatic test_glitch();
      int wrong;
      int hl, hr;
      mode = 2'b01;
      repeat (3) stepCycle();
      mode = 2'b11;
      wrong = 0;
      for (int i = 0; i < 10; i++) begin
         stepCycle();
         if (motion !== 2'b11) wrong++;
      end
      total++;
      if (wrong != 0) begin
         bad++; $display("[TB] FAIL glitch_motion: got %0d off-cycles want 0", wrong);
      end
      total++;
      if (dut.curLeft_q !== 7'd80 || dut.curRight_q !== 7'd80) begin
         bad++; $display("[TB] FAIL glitch_duty: got %0d/%0d want 80/80", dut.curLeft_q, dut.curRight_q);
      end
      hl = 0; hr = 0;
      for (int i = 0; i < 100; i++) begin
         stepCycle();
         hl += int'(left_pwm);
         hr += int'(right_pwm);
      end
      total++;
      if (hl != 80 || hr != 80) begin
         bad++; $display("[TB] FAIL glitch_highs: got %0d/%0d want 80/80", hl, hr);
      end
   endtask

   task automatic test_left_turn();
      logic [6:0] prev;
      bit got;
      int hl, hr;
      phaseErr = 0;
      track = 1'b1;
      mode = 2'b01;
      repeat (3) stepCycle();
      total++;
      if (motion !== 2'b11) begin
         bad++; $display("[TB] FAIL left_early: got %b want 11", motion);
      end
      stepCycle();
      total++;
      if (motion !== 2'b01 || {left_dir, right_dir} !== 4'b1010) begin
         bad++; $display("[TB] FAIL left_adopt: got %b/%b want 01/1010", motion, {left_dir, right_dir});
      end
      for (int k = 1; k <= 6; k++) begin
         prev = dut.curLeft_q;
         got = 1'b0;
         for (int i = 0; i < 60 && !got; i++) begin
            stepCycle();
            if (dut.curLeft_q !== prev) got = 1'b1;
         end
         total++;
         if (!got || dut.curLeft_q !== 7'(80 - 10 * k) || dut.curRight_q !== 7'd70) begin
            bad++; $display("[TB] FAIL left_ramp%0d: got %0d/%0d want %0d/70", k, dut.curLeft_q, dut.curRight_q, 80 - 10 * k);
         end
      end
      repeat (70) stepCycle();
      total++;
      if (dut.curLeft_q !== 7'd20 || dut.curRight_q !== 7'd70) begin
         bad++; $display("[TB] FAIL left_settle: got %0d/%0d want 20/70", dut.curLeft_q, dut.curRight_q);
      end
      repeat (150) stepCycle();
      hl = 0; hr = 0;
      for (int i = 0; i < 100; i++) begin
         stepCycle();
         hl += int'(left_pwm);
         hr += int'(right_pwm);
      end
      track = 1'b0;
      total++;
      if (hl != 20 || hr != 70) begin
         bad++; $display("[TB] FAIL left_highs: got %0d/%0d want 20/70", hl, hr);
      end
      total++;
      if (phaseErr != 0) begin
         bad++; $display("[TB] FAIL left_midperiod: got %0d off-phase events want 0", phaseErr);
      end
   endtask

   task automatic test_stop();
      int i;
      int hl, hr;
      mode = 2'b11;
      for (i = 0; i < 600 && !(dut.curLeft_q === 7'd80 && dut.curRight_q === 7'd80); i++)
         stepCycle();
      total++;
      if (i >= 600) begin
         bad++; $display("[TB] FAIL stop_prep: got %0d/%0d want 80/80", dut.curLeft_q, dut.curRight_q);
      end
      repeat (150) stepCycle();
      mode = 2'b00;
      repeat (3) stepCycle();
      total++;
      if (motion !== 2'b11) begin
         bad++; $display("[TB] FAIL stop_early: got %b want 11", motion);
      end
      stepCycle();
      total++;
      if (motion !== 2'b00 || {left_dir, right_dir} !== 4'b0000) begin
         bad++; $display("[TB] FAIL stop_adopt: got %b/%b want 00/0000", motion, {left_dir, right_dir});
      end
      total++;
      if (dut.actLeft_q !== 7'd0 || dut.actRight_q !== 7'd0 ||
          dut.curLeft_q !== 7'd0 || dut.curRight_q !== 7'd0) begin
         bad++; $display("[TB] FAIL stop_duty: got act %0d/%0d cur %0d/%0d want zeros",
                         dut.actLeft_q, dut.actRight_q, dut.curLeft_q, dut.curRight_q);
      end
      stepCycle();
      hl = 0; hr = 0;
      for (int j = 0; j < 100; j++) begin
         hl += int'(left_pwm);
         hr += int'(right_pwm);
         stepCycle();
      end
      total++;
      if (hl != 0 || hr != 0) begin
         bad++; $display("[TB] FAIL stop_pwm_low: got %0d/%0d highs want 0/0", hl, hr);
      end
   endtask

   task automatic test_reset_midramp();
      int i;
      logic [6:0] prev;
      bit got;
      mode = 2'b11;
      for (i = 0; i < 400 && dut.curLeft_q !== 7'd40; i++) stepCycle();
      total++;
      if (i >= 400) begin
         bad++; $display("[TB] FAIL midramp_reach: got %0d want 40", dut.curLeft_q);
      end
      reset = 1'b1;
      stepCycle();
      total++;
      if (motion !== 2'b00 || {left_dir, right_dir} !== 4'b0000 || {left_pwm, right_pwm} !== 2'b00) begin
         bad++; $display("[TB] FAIL midramp_outputs: got %b %b %b want 00 0000 00",
                         motion, {left_dir, right_dir}, {left_pwm, right_pwm});
      end
      total++;
      if (dut.curLeft_q !== 7'd0 || dut.curRight_q !== 7'd0) begin
         bad++; $display("[TB] FAIL midramp_duty: got %0d/%0d want 0/0", dut.curLeft_q, dut.curRight_q);
      end
      reset = 1'b0;
      repeat (3) stepCycle();
      total++;
      if (motion !== 2'b00) begin
         bad++; $display("[TB] FAIL midramp_early: got %b want 00", motion);
      end
      stepCycle();
      total++;
      if (motion !== 2'b11) begin
         bad++; $display("[TB] FAIL midramp_readopt: got %b want 11", motion);
      end
      prev = dut.curLeft_q;
      got = 1'b0;
      for (int j = 0; j < 60 && !got; j++) begin
         stepCycle();
         if (dut.curLeft_q !== prev) got = 1'b1;
      end
      total++;
      if (!got || dut.curLeft_q !== 7'd10) begin
         bad++; $display("[TB] FAIL midramp_restart: got %0d want 10", dut.curLeft_q);
      end
   endtask

   task automatic test_full_duty();
      int hl, hr;
      reset2 = 1'b1;
      repeat (2) stepCycle();
      reset2 = 1'b0;
      mode2 = 2'b11;
      repeat (700) stepCycle();
      hl = 0; hr = 0;
      for (int i = 0; i < 100; i++) begin
         stepCycle();
         hl += int'(left_pwm2);
         hr += int'(right_pwm2);
      end
      total++;
      if (hl != 100 || hr != 100) begin
         bad++; $display("[TB] FAIL full_duty_highs: got %0d/%0d want 100/100", hl, hr);
      end
      mode2 = 2'b01;
      repeat (700) stepCycle();
      hl = 0; hr = 0;
      for (int i = 0; i < 100; i++) begin
         stepCycle();
         hl += int'(left_pwm2);
         hr += int'(right_pwm2);
      end
      total++;
      if (hl != 0 || hr != 70) begin
         bad++; $display("[TB] FAIL zero_slow_highs: got %0d/%0d want 0/70", hl, hr);
      end
      total++;
      if (left_dir2 !== 2'b10 || motion2 !== 2'b01) begin
         bad++; $display("[TB] FAIL zero_slow_dir: got %b/%b want 10/01", left_dir2, motion2);
      end
   endtask

   initial begin
      test_reset();
      test_fwd_ramp();
      test_glitch();
      test_left_turn();
      test_stop();
      test_reset_midramp();
      test_full_duty();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/motor_drive.md
# motor_drive

Motor drive stage that sits directly downstream of the line-tracker sensor block. It consumes the tracker's 2-bit steering state (00 stop, 01 left, 10 right, 11 forward) and debounces it. It ramps per-wheel duty toward a per-state target and generates glitch-free PWM and direction outputs for the left and right H-bridge channels.

## Interface
- PWM_PERIOD, 100: PWM period in clk cycles. Duty width W = $clog2(PWM_PERIOD+1).
- FWD_DUTY, 80: duty applied to both wheels in FWD.
- TURN_FAST, 70: outer-wheel duty in a turn.
- TURN_SLOW, 20: inner-wheel duty in a turn.
- RAMP_STEP, 10: duty change applied per ramp tick.
- RAMP_DIV, 50: clk cycles between ramp ticks.
- HOLD_CYCLES, 4: consecutive cycles a new mode must be stable before it is adopted (≥1).
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- mode  in  2  steering state from tracker: 00 stop, 01 left, 10 right, 11 forward.
- left_pwm  out  1  left-wheel PWM.
- right_pwm  out  1  right-wheel PWM.
- left_dir  out  2  left H-bridge IN1/IN2: 2'b10 drive forward, 2'b00 coast.
- right_dir  out  2  right H-bridge IN1/IN2, same encoding.
- motion  out  2  currently adopted command, same encoding as mode.

## Operation
- Debounce:
  - Register the candidate value and keep a stable counter. The counter clears to 1 whenever mode differs from the candidate, and the candidate reloads.
  - When the counter reaches HOLD_CYCLES with the candidate ≠ motion, set motion <= candidate.
  - Any glitch shorter than HOLD_CYCLES is ignored.
- FSM states STOP, LEFT, RIGHT, FWD map 1:1 onto motion. Transitions follow only the debounced command; any state may go to any other.
- Targets as (left, right):
  - STOP = (0, 0)
  - FWD = (FWD_DUTY, FWD_DUTY)
  - LEFT = (TURN_SLOW, TURN_FAST)
  - RIGHT = (TURN_FAST, TURN_SLOW)
- Ramp tick counter:
  - Free-runs 0..RAMP_DIV-1 and asserts tick on wrap.
  - On each tick, each wheel's duty_cur moves toward its target by RAMP_STEP and saturates exactly at target, with no overshoot or underflow.
  - Ramps apply both upward and downward.
- STOP override: on entering STOP, duty_cur and duty_act of both wheels clear to 0 on the same edge that updates motion. Stop is never ramped.
- PWM counter:
  - Free-runs 0..PWM_PERIOD-1.
  - duty_act <= duty_cur only on the cycle the counter equals PWM_PERIOD-1, so the duty never changes mid-period, except for the STOP override.
  - pwm = registered (pwm_cnt < duty_act). duty 0 gives constant low; duty PWM_PERIOD gives constant high.
- Direction: dir = 2'b10 in LEFT, RIGHT and FWD; 2'b00 in STOP. Updates on the same edge as motion.
- Parameter legality: all duties ≤ PWM_PERIOD, RAMP_STEP ≥ 1, RAMP_DIV ≥ 1. Illegal values are unsupported, with no runtime checking.

## Timing
- Reset (synchronous) clears the following:
  - motion=00 and FSM=STOP.
  - candidate=00 and stable counter=0.
  - pwm_cnt=0 and ramp counter=0.
  - duty_cur=duty_act=0 for both wheels.
  - left_pwm=right_pwm=0 and left_dir=right_dir=00.
- Reset asserted mid-ramp or mid-period aborts immediately. The first post-reset cycle behaves exactly like power-up.
- Debounce latency: a mode value first sampled at edge k is adopted at edge k+HOLD_CYCLES-1. motion and dir are visible the cycle after that edge.
- Ramp latency: the first duty_cur step occurs at the next ramp tick after adoption, up to RAMP_DIV cycles. duty_act follows at the next PWM wrap, up to PWM_PERIOD cycles.
- The pwm outputs are registered, so they lag pwm_cnt by 1 cycle.
- Simultaneous events:
  - If a ramp tick and a PWM wrap occur on the same edge, duty_act takes the pre-tick duty_cur; the new value loads at the following wrap.
  - If adoption and a tick occur on the same edge, the tick steps toward the old target.
- A mode change while ramping retargets from the current duty_cur without resetting the ramp counter.

## Test plan
- Reset, then mode=11 held: motion=11 after 4 edges, dir=10/10. duty_cur reaches 10,20,…,80 on successive ticks (8 ticks, 400 cycles). Steady state: each pwm high exactly 80 of every 100 cycles.
- 3-cycle glitch of mode=01 during steady FWD: motion stays 11, and duties and pwm are unchanged.
- FWD at 80/80, then mode=01 held: left ramps 80→70→…→20 over 6 ticks and right ramps 80→70 in 1 tick, with no overshoot. No pwm pulse is truncated or extended mid-period.
- FWD at 80/80, then mode=00 held 4 cycles: on the adoption edge duty_act=0 for both wheels and dir=00. The pwm outputs are low from the next cycle with no ramp-down.
- Assert reset for 1 cycle mid-ramp (duty_cur=40) with mode=11 still applied: all outputs 0 the next cycle. The ramp restarts from 0, and motion re-adopts 11 after 4 cycles.
- Override parameters with PWM_PERIOD=100 and FWD_DUTY=100: pwm held constant high in steady FWD. With TURN_SLOW=0 in LEFT, left_pwm is constant low while left_dir stays 10.
